// File: rtl/pma_rx.sv
// PMA receive aligner: shifts serial bits into 10-bit code-groups, locking on commas.
// Optional PMA_RX_REALIGN_COUNT_EN adds a saturating counter of off-phase comma realignments.
module pma_rx (
  input  logic       Clk,
  input  logic       mr_main_reset,
  input  logic       rx_bit,
  input  logic       signal_detect,
  input  logic       comma_detect_en,
  output logic [9:0] PUDI,
  output logic       PUDI_indicate,
  output logic       aligned,
  output logic [7:0] realign_count
);

  // state        | meaning
  // ST_UNALIGNED | no code-group boundary known, waiting for an enabled comma
  // ST_ALIGNED   | boundary locked, emitting one code-group every 10 bits
  typedef enum logic {ST_UNALIGNED, ST_ALIGNED} state_t;

  state_t     state_q, state_d;
  logic [8:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] pudi_q, pudi_d;
  logic       ind_q, ind_d;
  logic [9:0] window;
  logic       comma;
  logic       boundary;

  assign window = {sr_q, rx_bit};
  assign comma  = (window[9:3] == 7'b0011111) || (window[9:3] == 7'b1100000);

  always_comb begin
    state_d  = state_q;
    sr_d     = window[8:0];
    cnt_d    = cnt_q;
    pudi_d   = pudi_q;
    ind_d    = 1'b0;
    boundary = 1'b0;
    if (!signal_detect) begin
      state_d = ST_UNALIGNED;
      cnt_d   = 4'd0;
    end else if (state_q == ST_UNALIGNED) begin
      if (comma && comma_detect_en) begin
        boundary = 1'b1;
        state_d  = ST_ALIGNED;
      end
    end else begin
      // A comma landing on cnt==9 is just the regular boundary.
      if (cnt_q == 4'd9 || (comma && comma_detect_en)) begin
        boundary = 1'b1;
      end
    end
    if (boundary) begin
      cnt_d  = 4'd0;
      pudi_d = window;
      ind_d  = 1'b1;
    end else if (signal_detect && state_q == ST_ALIGNED) begin
      // Phase is meaningless while unaligned, so it rests at 0 there.
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (mr_main_reset) begin
      state_q <= ST_UNALIGNED;
      sr_q    <= 9'd0;
      cnt_q   <= 4'd0;
      pudi_q  <= 10'h000;
      ind_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pudi_q  <= pudi_d;
      ind_q   <= ind_d;
    end
  end

  assign PUDI          = pudi_q;
  assign PUDI_indicate = ind_q;
  assign aligned       = (state_q == ST_ALIGNED);

`ifdef PMA_RX_REALIGN_COUNT_EN
  logic [7:0] rc_q, rc_d;
  logic       realign;

  assign realign = signal_detect && (state_q == ST_ALIGNED) && comma && comma_detect_en
                   && (cnt_q != 4'd9);

  always_comb begin
    rc_d = rc_q;
    if (realign && rc_q != 8'hFF) rc_d = rc_q + 8'd1;
  end

  always_ff @(posedge Clk) begin
    if (mr_main_reset) rc_q <= 8'h00;
    else               rc_q <= rc_d;
  end

  assign realign_count = rc_q;
`else
  assign realign_count = 8'h00;
`endif

endmodule

// File: tb/tb_pma_rx.sv
// Directed bench for pma_rx: comma lock, free-running phase, realignment, signal loss, reset.
module tb_pma_rx;
  logic       Clk = 1'b0;
  logic       mr_main_reset;
  logic       rx_bit;
  logic       signal_detect;
  logic       comma_detect_en;
  logic [9:0] PUDI;
  logic       PUDI_indicate;
  logic       aligned;
  logic [7:0] realign_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int last_strobe = 0;

`ifdef PMA_RX_REALIGN_COUNT_EN
  localparam logic [7:0] RC_AFTER_REALIGN = 8'd1;
`else
  localparam logic [7:0] RC_AFTER_REALIGN = 8'd0;
`endif

  pma_rx dut (
    .Clk(Clk), .mr_main_reset(mr_main_reset), .rx_bit(rx_bit),
    .signal_detect(signal_detect), .comma_detect_en(comma_detect_en),
    .PUDI(PUDI), .PUDI_indicate(PUDI_indicate), .aligned(aligned),
    .realign_count(realign_count)
  );

  always #5 Clk = ~Clk;

  task automatic send_bit(input logic b);
    rx_bit = b;
    @(posedge Clk);
    #1;
    cyc++;
    if (PUDI_indicate === 1'b1) begin
      strobes++;
      last_strobe = cyc;
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    mr_main_reset = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if (PUDI !== 10'h000 || PUDI_indicate !== 1'b0 || aligned !== 1'b0 || realign_count !== 8'h00) begin
      errors++;
      $display("FAIL reset: PUDI=%h ind=%b aligned=%b rc=%h, want 000 0 0 00",
               PUDI, PUDI_indicate, aligned, realign_count);
    end
    mr_main_reset = 1'b0;
  endtask

  task automatic test_comma_align();
    int s0;
    logic [9:0] w;
    s0 = strobes;
    w = 10'h0FA;
    for (int i = 9; i >= 1; i--) send_bit(w[i]);
    checks++;
    if (strobes !== s0 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL unaligned_quiet: strobes=%0d aligned=%b, want %0d 0", strobes, aligned, s0);
    end
    send_bit(w[0]);
    checks++;
    if (PUDI !== 10'h0FA || PUDI_indicate !== 1'b1 || aligned !== 1'b1) begin
      errors++;
      $display("FAIL k28_5_lock: PUDI=%h ind=%b aligned=%b, want 0fa 1 1", PUDI, PUDI_indicate, aligned);
    end
  endtask

  task automatic test_data_word();
    int t0;
    logic [9:0] w;
    t0 = last_strobe;
    w = 10'h245;
    send_bit(w[9]);
    checks++;
    if (PUDI_indicate !== 1'b0 || PUDI !== 10'h0FA) begin
      errors++;
      $display("FAIL pudi_hold: PUDI=%h ind=%b, want 0fa 0", PUDI, PUDI_indicate);
    end
    for (int i = 8; i >= 0; i--) send_bit(w[i]);
    checks++;
    if (PUDI !== 10'h245 || PUDI_indicate !== 1'b1 || (last_strobe - t0) != 10 ||
        realign_count !== 8'h00) begin
      errors++;
      $display("FAIL d16_2: PUDI=%h ind=%b gap=%0d rc=%h, want 245 1 10 00",
               PUDI, PUDI_indicate, last_strobe - t0, realign_count);
    end
  endtask

  task automatic test_realign();
    int s0, t0;
    logic [9:0] w;
    s0 = strobes;
    w = 10'h305;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    for (int i = 9; i >= 3; i--) send_bit(w[i]);
    checks++;
    if (PUDI !== 10'h160 || PUDI_indicate !== 1'b1) begin
      errors++;
      $display("FAIL old_phase_word: PUDI=%h ind=%b, want 160 1", PUDI, PUDI_indicate);
    end
    for (int i = 2; i >= 0; i--) send_bit(w[i]);
    checks++;
    if (PUDI !== 10'h305 || PUDI_indicate !== 1'b1 || strobes != s0 + 2 ||
        realign_count !== RC_AFTER_REALIGN || aligned !== 1'b1) begin
      errors++;
      $display("FAIL realign: PUDI=%h ind=%b strobes=%0d rc=%h, want 305 1 %0d %h",
               PUDI, PUDI_indicate, strobes - s0, realign_count, 2, RC_AFTER_REALIGN);
    end
    t0 = last_strobe;
    send_word(10'h245);
    checks++;
    if (PUDI !== 10'h245 || PUDI_indicate !== 1'b1 || (last_strobe - t0) != 10 ||
        strobes != s0 + 3 || realign_count !== RC_AFTER_REALIGN) begin
      errors++;
      $display("FAIL new_phase: PUDI=%h ind=%b gap=%0d rc=%h, want 245 1 10 %h",
               PUDI, PUDI_indicate, last_strobe - t0, realign_count, RC_AFTER_REALIGN);
    end
  endtask

  task automatic test_comma_disabled();
    int s0, t0;
    logic [9:0] w;
    s0 = strobes;
    t0 = last_strobe;
    w = 10'h305;
    comma_detect_en = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    for (int i = 9; i >= 3; i--) send_bit(w[i]);
    checks++;
    if (PUDI !== 10'h160 || PUDI_indicate !== 1'b1) begin
      errors++;
      $display("FAIL dis_first: PUDI=%h ind=%b, want 160 1", PUDI, PUDI_indicate);
    end
    for (int i = 2; i >= 0; i--) send_bit(w[i]);
    checks++;
    if (PUDI_indicate !== 1'b0 || PUDI !== 10'h160) begin
      errors++;
      $display("FAIL dis_no_realign: PUDI=%h ind=%b, want 160 0", PUDI, PUDI_indicate);
    end
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    checks++;
    if (PUDI !== 10'h280 || PUDI_indicate !== 1'b1 || strobes != s0 + 2 ||
        (last_strobe - t0) != 20 || realign_count !== RC_AFTER_REALIGN) begin
      errors++;
      $display("FAIL dis_old_phase: PUDI=%h ind=%b strobes=%0d span=%0d rc=%h, want 280 1 2 20 %h",
               PUDI, PUDI_indicate, strobes - s0, last_strobe - t0, realign_count, RC_AFTER_REALIGN);
    end
  endtask

  task automatic test_signal_loss();
    int s0;
    signal_detect = 1'b0;
    send_bit(1'b0);
    signal_detect = 1'b1;
    checks++;
    if (aligned !== 1'b0 || PUDI_indicate !== 1'b0) begin
      errors++;
      $display("FAIL sig_loss: aligned=%b ind=%b, want 0 0", aligned, PUDI_indicate);
    end
    comma_detect_en = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 7; i++) begin
      send_bit(1'b0);
      send_bit(1'b1);
    end
    checks++;
    if (strobes != s0 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL sig_loss_quiet: strobes=%0d aligned=%b, want 0 0", strobes - s0, aligned);
    end
    send_word(10'h0FA);
    checks++;
    if (PUDI !== 10'h0FA || PUDI_indicate !== 1'b1 || aligned !== 1'b1) begin
      errors++;
      $display("FAIL relock: PUDI=%h ind=%b aligned=%b, want 0fa 1 1", PUDI, PUDI_indicate, aligned);
    end
  endtask

  task automatic test_reset_mid_word();
    int s0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    mr_main_reset = 1'b1;
    send_bit(1'b0);
    checks++;
    if (PUDI !== 10'h000 || PUDI_indicate !== 1'b0 || aligned !== 1'b0 || realign_count !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: PUDI=%h ind=%b aligned=%b rc=%h, want 000 0 0 00",
               PUDI, PUDI_indicate, aligned, realign_count);
    end
    mr_main_reset = 1'b0;
    s0 = strobes;
    send_word(10'h245);
    checks++;
    if (strobes != s0 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_unaligned: strobes=%0d aligned=%b, want 0 0", strobes - s0, aligned);
    end
    send_word(10'h0FA);
    checks++;
    if (PUDI !== 10'h0FA || PUDI_indicate !== 1'b1 || aligned !== 1'b1 || strobes != s0 + 1) begin
      errors++;
      $display("FAIL post_reset_lock: PUDI=%h ind=%b aligned=%b strobes=%0d, want 0fa 1 1 1",
               PUDI, PUDI_indicate, aligned, strobes - s0);
    end
  endtask

  initial begin
    mr_main_reset   = 1'b1;
    rx_bit          = 1'b0;
    signal_detect   = 1'b1;
    comma_detect_en = 1'b1;
    test_reset();
    test_comma_align();
    test_data_word();
    test_realign();
    test_comma_disabled();
    test_signal_loss();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pma_rx.md
PMA_RX -- requirements
Module: pma_rx

Interface
REQ-001 SHALL have ports: Clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have ports: mr_main_reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: rx_bit  in  1  serial receive bit, one new bit sampled every Clk.
REQ-004 SHALL have ports: signal_detect  in  1  line-present indication; 0 forces loss of alignment.
REQ-005 SHALL have ports: comma_detect_en  in  1  1 permits comma-driven (re)alignment.
REQ-006 SHALL have ports: PUDI  out  10  aligned code-group, bit 9 = 'a' (first received), bit 0 = 'j'.
REQ-007 SHALL have ports: PUDI_indicate  out  1  one-cycle strobe, PUDI valid.
REQ-008 SHALL have ports: aligned  out  1  code-group boundary locked.
REQ-009 SHALL have ports: realign_count  out  8  saturating count of boundary moves (see Configuration).

Function
REQ-010 Each edge SHALL form window = {sr[8:0], rx_bit} and load sr <= window; first received bit ends in window[9].
REQ-011 A comma SHALL be window[9:3] == 7'b0011111 or 7'b1100000.
REQ-012 A phase counter cnt (0..9) SHALL count bits since the last boundary; a boundary edge loads cnt <= 0, any other edge loads cnt <= cnt+1 (wrap 9 -> 0 only via boundary).
REQ-013 Unaligned state: comma with comma_detect_en=1 and signal_detect=1 SHALL be a boundary; set aligned <= 1, emit window.
REQ-014 Aligned state: edge with cnt==9 SHALL be a boundary; emit window.
REQ-015 Aligned state: comma with comma_detect_en=1 and cnt!=9 SHALL be a realignment boundary; emit window, increment realign_count.
REQ-016 Comma coinciding with cnt==9 SHALL be a normal boundary; realign_count unchanged.
REQ-017 comma_detect_en=0 SHALL ignore commas; aligned state keeps free-running boundaries, unaligned state stays unaligned.
REQ-018 Emit SHALL mean PUDI <= window and PUDI_indicate <= 1 at that edge; latency one cycle after the last bit ('j') is sampled.
REQ-019 PUDI_indicate SHALL be 0 on every non-boundary edge; PUDI holds its last emitted value between strobes.
REQ-020 Unaligned state SHALL never assert PUDI_indicate.
REQ-021 signal_detect=0 at an edge SHALL force aligned <= 0, cnt <= 0, PUDI_indicate <= 0; sr still shifts; takes priority over REQ-013..015.
REQ-022 In steady aligned operation PUDI_indicate SHALL assert exactly once every 10 Clk cycles.

Reset
REQ-023 mr_main_reset=1 at an edge SHALL clear sr, cnt, PUDI (10'h000), PUDI_indicate, aligned, realign_count to 0, overriding all other inputs.
REQ-024 Reset asserted mid-code-group SHALL discard partial bits; alignment restarts from unaligned state after deassertion.

Configuration
REQ-025 Macro PMA_RX_REALIGN_COUNT_EN defined: realign_count SHALL implement REQ-015, saturating at 8'hFF.
REQ-026 Macro PMA_RX_REALIGN_COUNT_EN undefined: realign_count SHALL be constant 8'h00 and no counter logic SHALL be synthesized; all other behaviour identical.

Verification
REQ-027 Reset, then serial K28.5 RD- bits 0,0,1,1,1,1,1,0,1,0 with comma_detect_en=1, signal_detect=1 -> next cycle PUDI=10'h0FA, PUDI_indicate=1, aligned=1.
REQ-028 Following D16.2 bits 1,0,0,1,0,0,0,1,0,1 -> PUDI=10'h245 strobe exactly 10 cycles after the previous strobe, realign_count unchanged.
REQ-029 Aligned; insert 3 stray bits, then K28.5 RD+ (10'h305) -> strobe with PUDI=10'h305 off-phase, realign_count=1, strobes every 10 cycles thereafter.
REQ-030 Aligned, comma_detect_en=0, off-phase comma injected -> no realignment, strobes stay on old phase, realign_count unchanged.
REQ-031 signal_detect dropped 1 cycle while aligned -> aligned=0 next cycle, no strobes until next comma; mr_main_reset mid-word -> all outputs 0 next cycle.
REQ-032 Build without PMA_RX_REALIGN_COUNT_EN, repeat REQ-029 -> realign_count=8'h00, PUDI and strobes identical.
